multi_byte_adder_ctrl: RTL and testbench

MULTI_BYTE_ADDER_CTRL -- requirements
Module: multi_byte_adder_ctrl

---
 rtl/multi_byte_adder_ctrl.sv | 162 ++++++++++++++++
 tb/tb_multi_byte_adder_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_byte_adder_ctrl.sv
// Multi-byte add/subtract controller: one shared 8-bit ripple-carry adder is
// reused once per byte, least-significant byte first, with the carry held in a register.

module ripple_carry_adder (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum_c,
    output logic       o_cout_c
);

    logic [8:0] w_carry;

    assign w_carry[0] = i_cin;

    // Classic full-adder chain
    for (genvar g = 0; g < 8; g++) begin : g_fa
        assign o_sum_c[g]   = i_a[g] ^ i_b[g] ^ w_carry[g];
        assign w_carry[g+1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout_c = w_carry[8];

endmodule

module multi_byte_adder_ctrl #(
    parameter int unsigned N_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_sub,
    input  logic                 cin,
    input  logic [8*N_BYTES-1:0] a,
    input  logic [8*N_BYTES-1:0] b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [8*N_BYTES-1:0] sum,
    output logic                 cout,
    output logic                 overflow
);

    localparam int unsigned W      = 8 * N_BYTES;
    localparam int unsigned IDX_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int unsigned BASE_W = IDX_W + 3;
    localparam int unsigned LAST   = N_BYTES - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_op_sub;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic [BASE_W-1:0]  w_base;
    logic [7:0]         w_a_byte;
    logic [7:0]         w_b_eff_byte;
    logic [7:0]         w_add_sum;
    logic               w_add_cout;
    logic               w_ovf;

    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_last       = (r_idx == IDX_W'(LAST));
    assign w_base       = {r_idx, 3'b000};
    assign w_a_byte     = r_a[w_base +: 8];
    assign w_b_eff_byte = r_b[w_base +: 8] ^ {8{r_op_sub}};

    // Sign rule on the latched operands; the MSB of the result comes from the last byte
    assign w_ovf = (r_a[W-1] == (r_b[W-1] ^ r_op_sub)) && (w_add_sum[7] != r_a[W-1]);

    ripple_carry_adder u_rca (
        .i_a      (w_a_byte),
        .i_b      (w_b_eff_byte),
        .i_cin    (r_carry),
        .o_sum_c  (w_add_sum),
        .o_cout_c (w_add_cout)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op_sub <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == S_IDLE);
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_op_sub <= op_sub;
                r_carry  <= op_sub | cin;
                r_idx    <= '0;
                r_sum    <= '0;
            end else if (r_state == S_RUN) begin
                r_sum[w_base +: 8] <= w_add_sum;
                r_carry            <= w_add_cout;
                // Index parks on the last byte; it is reloaded by the next start
                if (w_last) begin
                    r_cout <= w_add_cout;
                    r_ovf  <= w_ovf;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign ready    = r_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_multi_byte_adder_ctrl.sv
// Self-checking bench for multi_byte_adder_ctrl (N_BYTES=4): directed table,
// hand-written reset/ignore sequences, and random operations against an arithmetic model.

module tb_multi_byte_adder_ctrl;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_run;
    int n_fail;

    typedef struct {
        logic         s;
        logic         c;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    vec_t vecs [6];

    multi_byte_adder_ctrl #(.N_BYTES(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_sub   (op_sub),
        .cin      (cin),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on whole operands
    task automatic model(input logic s, input logic c, input logic [W-1:0] av,
                         input logic [W-1:0] bv, output logic [W-1:0] es,
                         output logic ec, output logic eo);
        longint sa, sb, sr;
        longint unsigned ua, ub, ur;
        ua = longint'(av);
        ub = longint'(bv);
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (!s) begin
            ur = ua + ub + longint'(c);
            ec = (ur > 64'hFFFF_FFFF);
            sr = sa + sb + longint'(c);
            es = av + bv + W'(c);
        end else begin
            ec = (ua >= ub);
            sr = sa - sb;
            es = av - bv;
        end
        eo = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    // One operation from start to return-to-idle, checking timing and results.
    // With noisy=1, start and operands are scrambled every cycle after acceptance.
    task automatic run_op(input logic s, input logic c, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] es,
                          input logic ec, input logic eo, input bit noisy, input string tag);
        int done_at;
        int pulses;
        done_at = -1;
        pulses  = 0;
        @(negedge clk);
        start = 1'b1; op_sub = s; cin = c; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
        for (int k = 1; k <= int'(NB); k++) begin
            if (noisy) begin
                @(negedge clk);
                start = 1'b1; a = $urandom; b = $urandom; op_sub = ~s; cin = ~c;
            end
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (done_at < 0) done_at = k;
            end
        end
        chk({tag, " done_latency"}, 64'(done_at), 64'(NB));
        chk({tag, " sum"}, 64'(sum), 64'(es));
        chk({tag, " cout"}, 64'(cout), 64'(ec));
        chk({tag, " overflow"}, 64'(overflow), 64'(eo));
        @(posedge clk); #1;
        start = 1'b0;
        if (done) pulses++;
        chk({tag, " done_pulses"}, 64'(pulses), 64'd1);
        chk({tag, " ready_after"}, 64'({ready, busy}), 64'b10);
        chk({tag, " sum_held"}, 64'(sum), 64'(es));
    endtask

    initial begin
        logic [W-1:0] es;
        logic         ec, eo;
        int           pulses;

        n_run  = 0;
        n_fail = 0;
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0; a = '0; b = '0;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_FFFF, 32'h0000_0000, 32'h0001_0000, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset flags", 64'({ready, busy, done, cout, overflow}), 64'b10000);
        chk("reset sum", 64'(sum), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table; consecutive entries also exercise back-to-back issue
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].s, vecs[i].c, vecs[i].av, vecs[i].bv,
                   vecs[i].es, vecs[i].ec, vecs[i].eo, 1'b0, $sformatf("vec%0d", i));
        end

        // Starts and operand changes while running must not disturb the result
        run_op(1'b0, 1'b0, 32'h1234_5678, 32'h0FED_CBA9, 32'h2222_2221, 1'b0, 1'b0,
               1'b1, "noisy_add");
        run_op(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0003, 32'h0000_000D, 1'b1, 1'b0,
               1'b1, "noisy_sub");

        // Reset while the byte index sits at 2
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; cin = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrun_rst sum", 64'(sum), 64'd0);
        chk("midrun_rst flags", 64'({ready, busy, done}), 64'b100);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("midrun_rst no_done", 64'(pulses), 64'd0);
        run_op(1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0,
               1'b0, "post_rst");

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic         rs, rc;
            logic [W-1:0] ra, rb;
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 0) rb = ra;
            model(rs, rc, ra, rb, es, ec, eo);
            run_op(rs, rc, ra, rb, es, ec, eo, (i % 5 == 0), $sformatf("rnd%0d", i));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("idle sum_hold", 64'(sum), 64'(es));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
